// File: rtl/uart_rx_oversampler.sv
// UART receive front end: 2-flop synchroniser, start-bit qualification,
// mid-bit sampling on the baud generator's oversample tick, byte assembly,
// and single-cycle valid / framing-error / parity-error pulses.
// Optional parity bit: define UART_RX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_rx_oversampler #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS);

  localparam logic [SCNT_W-1:0] SCNT_MID = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_END = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_END = BCNT_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [2:0]           r_state;
  logic [SCNT_W-1:0]    r_scnt;
  logic [BCNT_W-1:0]    r_bcnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_busy;

  logic [2:0]           w_state_nxt;
  logic [SCNT_W-1:0]    w_scnt_nxt;
  logic [BCNT_W-1:0]    w_bcnt_nxt;
  logic [DATA_BITS-1:0] w_shreg_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_valid_nxt;
  logic                 w_ferr_nxt;
  logic                 w_scnt_end;
  logic [SCNT_W-1:0]    w_scnt_inc;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_perr;
  logic w_par_bit_nxt;
  logic w_perr_nxt;
  logic w_par_ok;

  // Data parity combined with the received parity bit must equal the configured sense
  assign w_par_ok = ((^r_shreg) ^ r_par_bit) == 1'(PARITY_ODD);
`else
  logic w_unused_parity_cfg;

  assign w_unused_parity_cfg = (PARITY_ODD != 0);
`endif

  assign w_scnt_end = (r_scnt == SCNT_END);
  assign w_scnt_inc = w_scnt_end ? '0 : r_scnt + SCNT_W'(1);

  // Next-state, counter, shift register and pulse decode; everything holds when tick=0
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bcnt_nxt  = r_bcnt;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_rx_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit_nxt = r_par_bit;
    w_perr_nxt    = 1'b0;
`endif
    if (tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = ST_START;
            w_scnt_nxt  = '0;
            w_bcnt_nxt  = '0;
          end
        end
        ST_START: begin
          if (r_scnt == SCNT_MID) begin
            w_scnt_nxt  = '0;
            w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            w_scnt_nxt = r_scnt + SCNT_W'(1);
          end
        end
        ST_DATA: begin
          w_scnt_nxt = w_scnt_inc;
          if (w_scnt_end) begin
            w_shreg_nxt = {r_rx_s, r_shreg[DATA_BITS-1:1]};
            if (r_bcnt == BCNT_END) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end else begin
              w_bcnt_nxt = r_bcnt + BCNT_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          w_scnt_nxt = w_scnt_inc;
          if (w_scnt_end) begin
            w_par_bit_nxt = r_rx_s;
            w_state_nxt   = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          w_scnt_nxt = w_scnt_inc;
          if (w_scnt_end) begin
            if (r_rx_s) begin
              w_state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (w_par_ok) begin
                w_data_nxt  = r_shreg;
                w_valid_nxt = 1'b1;
              end else begin
                w_perr_nxt = 1'b1;
              end
`else
              w_data_nxt  = r_shreg;
              w_valid_nxt = 1'b1;
`endif
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          w_scnt_nxt = '0;
          if (r_rx_s) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_scnt_nxt  = '0;
          w_bcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Synchroniser, FSM state, datapath and registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= ST_IDLE;
      r_scnt    <= '0;
      r_bcnt    <= '0;
      r_shreg   <= '0;
      r_rx_data <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_nxt;
      r_scnt    <= w_scnt_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_rx_data <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      r_par_bit <= w_par_bit_nxt;
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule
